compare_monitor: RTL
====================

Name: compare_monitor

Overview:
- Downstream consumer of the 4-bit magnitude comparator's less/equal/greater flags.
- Samples the flags on a valid strobe, keeps saturating per-outcome event counts, and tracks the current run of consecutive "equal" results.
- Asserts a match-lock once the run reaches a programmable length; drops it on the first unequal result.
- Flags illegal flag combinations from the upstream comparator.

Parameters:
CNT_W, 8, width of each outcome counter; counters saturate at 2^CNT_W-1
RUN_LEN, 4, consecutive valid equal samples required to enter lock (legal range 1..2^RUN_W-1)
RUN_W, 3, width of run counter; run counter saturates at 2^RUN_W-1

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
valid_in  input  1  flags are valid this cycle
less  input  1  comparator flag w0<w1
equal  input  1  comparator flag w0==w1
greater  input  1  comparator flag w0>w1
clear  input  1  synchronous clear of counters, run and lock (not of FSM reset semantics beyond that)
less_cnt  output  CNT_W  number of valid less samples
equal_cnt  output  CNT_W  number of valid equal samples
greater_cnt  output  CNT_W  number of valid greater samples
run_cnt  output  RUN_W  current consecutive-equal run length
lock  output  1  match-lock status (level)
lock_lost  output  1  one-cycle pulse when leaving LOCKED due to less/greater
flag_err  output  1  one-cycle pulse: valid_in with flags not exactly one-hot

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high.
- Reset: all counters 0, run_cnt 0, lock 0, lock_lost 0, flag_err 0, FSM = TRACK.
- A reset asserted mid-run discards all state at the next edge.
- Registered outputs; effects of a sample appear one cycle after the edge on which valid_in=1 is sampled.
- Sample classification at an edge with valid_in=1:
  - one-hot less: less_cnt++, run_cnt <= 0
  - one-hot greater: greater_cnt++, run_cnt <= 0
  - one-hot equal: equal_cnt++, run_cnt++ (saturating)
  - any other combination (000, or two or more set): flag_err=1 for one cycle, no counter changes, run_cnt <= 0, FSM unchanged (lock not dropped by an error alone).
- valid_in=0: no state change; the run is neither broken nor advanced by idle cycles.
- Counters saturate at all-ones; no wrap, no error.
- FSM states TRACK, LOCKED; lock = (state==LOCKED).
  - TRACK -> LOCKED when an equal sample makes the post-increment run_cnt >= RUN_LEN. lock rises in the same cycle run_cnt shows RUN_LEN.
  - LOCKED stays LOCKED on further equal samples, idle cycles and flag errors.
  - LOCKED -> TRACK on a valid less or greater sample; lock_lost=1 for exactly that one cycle.
  - TRACK on less/greater: lock_lost stays 0.
- clear=1: same effect as reset on counters, run_cnt and lock (FSM -> TRACK), no lock_lost pulse.
  - clear has priority over a simultaneous valid sample; that sample is dropped and not counted.
- lock_lost and flag_err are 0 in every cycle not specified above.

Test Plan:
- rst high 2 cycles then low, no valid -> all counts 0, run_cnt 0, lock 0, pulses 0.
- valid samples E,E,E,E (RUN_LEN=4) -> run_cnt 1,2,3,4; lock=1 in the cycle after 4th E; equal_cnt=4.
- From lock: idle 3 cycles, then G -> lock stays 1 through idle; after G lock=0, lock_lost pulses once, greater_cnt=1, run_cnt=0.
- E,E,invalid flags 110,E -> flag_err pulses once, run resets, final run_cnt=1, equal_cnt=3, lock=0.
- CNT_W=2: drive 5 L samples -> less_cnt reads 1,2,3,3,3 (saturates, no wrap).
- While locked, clear=1 with a simultaneous valid E -> all counters 0, lock=0, lock_lost=0, sample not counted; rst mid-run (run_cnt=2) -> run_cnt=0 next cycle.

Source files
------------

// File: rtl/compare_monitor.sv
// compare_monitor
//   Downstream consumer of a 4-bit magnitude comparator's less/equal/greater
//   flags. On every valid strobe the flags are classified. For each outcome it
//   keeps a saturating count. It also tracks the current run of consecutive
//   equal results. Once that run reaches RUN_LEN, the match-lock is asserted.
//   Illegal (non one-hot) flag patterns are reported with a pulse.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   valid_in     flags are valid this cycle
//   less         comparator flag w0<w1
//   equal        comparator flag w0==w1
//   greater      comparator flag w0>w1
//   clear        synchronous clear of counters, run and lock
//   less_cnt     saturating count of valid less samples
//   equal_cnt    saturating count of valid equal samples
//   greater_cnt  saturating count of valid greater samples
//   run_cnt      current consecutive-equal run length (saturating)
//   lock         match-lock status (level)
//   lock_lost    one-cycle pulse when a less/greater sample breaks the lock
//   flag_err     one-cycle pulse for a valid sample whose flags are not one-hot
module compare_monitor #(
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 4,
  parameter int RUN_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             less,
  input  logic             equal,
  input  logic             greater,
  input  logic             clear,
  output logic [CNT_W-1:0] less_cnt,
  output logic [CNT_W-1:0] equal_cnt,
  output logic [CNT_W-1:0] greater_cnt,
  output logic [RUN_W-1:0] run_cnt,
  output logic             lock,
  output logic             lock_lost,
  output logic             flag_err
);

  typedef enum logic {
    TRACK  = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [RUN_W-1:0] RUN_LEN_V = RUN_W'(RUN_LEN);

  state_t           state_reg, state_next;
  logic [RUN_W-1:0] run_reg, run_next;
  logic             lost_reg, lost_next;
  logic             err_reg, err_next;

  // Sample classification. Each of these already includes valid_in.
  logic       is_less, is_equal, is_greater, is_bad;
  logic [2:0] hit;  // [0] less, [1] equal, [2] greater

  assign is_less    = valid_in &  less & ~equal & ~greater;
  assign is_equal   = valid_in & ~less &  equal & ~greater;
  assign is_greater = valid_in & ~less & ~equal &  greater;
  assign is_bad     = valid_in & ~(is_less | is_equal | is_greater);
  assign hit        = {is_greater, is_equal, is_less};

  // One saturating counter per outcome. A clear wins over a sample in the
  // same cycle, so that sample is dropped.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : gen_cnt
      logic [CNT_W-1:0] cnt_reg, cnt_next;

      always_comb begin
        cnt_next = cnt_reg;
        if (clear) begin
          cnt_next = '0;
        end else if (hit[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
    end
  endgenerate

  assign less_cnt    = gen_cnt[0].cnt_reg;
  assign equal_cnt   = gen_cnt[1].cnt_reg;
  assign greater_cnt = gen_cnt[2].cnt_reg;

  // Run length, lock FSM and event pulses.
  always_comb begin
    state_next = state_reg;
    run_next   = run_reg;
    lost_next  = 1'b0;
    err_next   = 1'b0;
    if (clear) begin
      state_next = TRACK;
      run_next   = '0;
    end else if (is_equal) begin
      if (run_reg != {RUN_W{1'b1}}) begin
        run_next = run_reg + 1'b1;
      end
      // Lock is judged on the post-increment run. This makes lock rise in
      // the same cycle that run_cnt first shows RUN_LEN.
      if (run_next >= RUN_LEN_V) begin
        state_next = LOCKED;
      end
    end else if (is_less || is_greater) begin
      run_next = '0;
      if (state_reg == LOCKED) begin
        state_next = TRACK;
        lost_next  = 1'b1;
      end
    end else if (is_bad) begin
      // A bad flag pattern breaks the run. On its own it does not drop an
      // existing lock.
      run_next = '0;
      err_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= TRACK;
      run_reg   <= '0;
      lost_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      run_reg   <= run_next;
      lost_reg  <= lost_next;
      err_reg   <= err_next;
    end
  end

  assign run_cnt   = run_reg;
  assign lock      = (state_reg == LOCKED);
  assign lock_lost = lost_reg;
  assign flag_err  = err_reg;

endmodule
